// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an LSB-first shifter,
// with bit timing taken from the samp_clk enable and an inverted-sense line.
module uart_tx #(
  parameter int Oversample = 3,
  parameter int StopBits   = 1
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       samp_clk,
  input  logic [7:0] in,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       bit_clk,
  output logic       out
);

  // state | meaning
  // IDLE  | line at 0, waiting for a strobe with the holding register full
  // START | start bit (line 1)
  // DATA  | eight data bits, LSB first, line = ~bit
  // STOP  | StopBits stop periods (line 0)
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic StopLast = (StopBits == 2) ? 1'b1 : 1'b0;

  state_t                state, state_nxt;
  logic [Oversample-1:0] cnt, cnt_nxt;
  logic [2:0]            bit_idx, bit_idx_nxt;
  logic                  stop_idx, stop_idx_nxt;
  logic [7:0]            shift, shift_nxt;
  logic [7:0]            hold, hold_nxt;
  logic                  ready_nxt, busy_nxt, bit_clk_nxt, out_nxt;
  logic                  wrap, load;

  // ready doubles as the "holding register empty" flag
  assign wrap = samp_clk && (cnt == '1);

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      hold     <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      bit_clk  <= 1'b0;
      out      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      shift    <= shift_nxt;
      hold     <= hold_nxt;
      ready    <= ready_nxt;
      busy     <= busy_nxt;
      bit_clk  <= bit_clk_nxt;
      out      <= out_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    shift_nxt    = shift;
    hold_nxt     = hold;
    ready_nxt    = ready;
    busy_nxt     = busy;
    bit_clk_nxt  = 1'b0;
    out_nxt      = out;
    load         = 1'b0;

    if (valid && ready) begin
      hold_nxt  = in;
      ready_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (samp_clk && !ready) load = 1'b1;
      end
      START: begin
        if (samp_clk) cnt_nxt = cnt + 1'b1;
        if (wrap) begin
          state_nxt   = DATA;
          out_nxt     = ~shift[0];
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = '0;
          bit_clk_nxt = 1'b1;
        end
      end
      DATA: begin
        if (samp_clk) cnt_nxt = cnt + 1'b1;
        if (wrap) begin
          bit_clk_nxt = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt    = STOP;
            out_nxt      = 1'b0;
            stop_idx_nxt = 1'b0;
          end else begin
            out_nxt     = ~shift[0];
            shift_nxt   = {1'b0, shift[7:1]};
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (samp_clk) cnt_nxt = cnt + 1'b1;
        if (wrap) begin
          if (stop_idx == StopLast) begin
            if (!ready) begin
              load = 1'b1;
            end else begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              out_nxt   = 1'b0;
            end
          end else begin
            stop_idx_nxt = stop_idx + 1'b1;
            bit_clk_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // a pending byte starts a frame immediately, including straight out of STOP
    if (load) begin
      state_nxt   = START;
      shift_nxt   = hold;
      ready_nxt   = 1'b1;
      busy_nxt    = 1'b1;
      out_nxt     = 1'b1;
      bit_clk_nxt = 1'b1;
      cnt_nxt     = '0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed plus random bench for uart_tx: every frame is compared cycle by cycle
// against a waveform built from a queue of accepted bytes.
module tb_uart_tx;

  logic       ref_clk = 1'b0;
  logic       reset = 1'b1;
  logic       samp_clk = 1'b0;
  logic       valid = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] din = 8'h00;

  logic ready1, busy1, bc1, out1;
  logic ready2, busy2, bc2, out2;

  wire valid1 = valid & ~sel;
  wire valid2 = valid & sel;
  wire rdy = sel ? ready2 : ready1;
  wire bsy = sel ? busy2 : busy1;
  wire bc  = sel ? bc2 : bc1;
  wire o   = sel ? out2 : out1;

  uart_tx #(.Oversample(3), .StopBits(1)) dut1 (
    .ref_clk(ref_clk), .reset(reset), .samp_clk(samp_clk), .in(din), .valid(valid1),
    .ready(ready1), .busy(busy1), .bit_clk(bc1), .out(out1));

  uart_tx #(.Oversample(3), .StopBits(2)) dut2 (
    .ref_clk(ref_clk), .reset(reset), .samp_clk(samp_clk), .in(din), .valid(valid2),
    .ready(ready2), .busy(busy2), .bit_clk(bc2), .out(out2));

  always #5 ref_clk = ~ref_clk;

  // one-cycle strobe every 8 ref_clk cycles
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge ref_clk);
      div = (div + 1) % 8;
      samp_clk = (div == 0);
    end
  end

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 2000) begin
      @(negedge ref_clk);
      n++;
    end
    chk("send_ready", rdy, 1);
    valid = 1'b1;
    din = b;
    @(negedge ref_clk);
    valid = 1'b0;
    q.push_back(b);
    chk("ready_fall", rdy, 0);
  endtask

  // called right after send: start bit must appear within one strobe period
  task automatic wait_start();
    int n;
    n = 0;
    while (bc !== 1'b1 && n < 20) begin
      @(negedge ref_clk);
      n++;
    end
    chk("start_seen", bc, 1);
    chk("latency", (n >= 1 && n <= 8), 1);
  endtask

  task automatic check_frame();
    logic [7:0] d;
    int ns, len, k;
    logic exp_o;
    chk("q_nonempty", (q.size() > 0), 1);
    d = (q.size() > 0) ? q.pop_front() : 8'h00;
    ns = sel ? 2 : 1;
    len = (9 + ns) * 64;
    for (int t = 0; t < len; t++) begin
      k = t / 64;
      if (k == 0) exp_o = 1'b1;
      else if (k <= 8) exp_o = ~d[k-1];
      else exp_o = 1'b0;
      chk("frame_out", o, exp_o);
      chk("frame_bit_clk", bc, (t % 64 == 0));
      chk("frame_busy", bsy, 1);
      @(negedge ref_clk);
    end
    if (q.size() > 0) begin
      chk("b2b_bit_clk", bc, 1);
      chk("b2b_out", o, 1);
      chk("b2b_busy", bsy, 1);
    end else begin
      chk("end_busy", bsy, 0);
      chk("end_out", o, 0);
      chk("end_bit_clk", bc, 0);
    end
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1;
    repeat (3) @(negedge ref_clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      chk("idle_out", out1, 0);
      chk("idle_ready", ready1, 1);
      chk("idle_busy", busy1, 0);
      chk("idle_bit_clk", bc1, 0);
      chk("idle_ready2", ready2, 1);
      @(negedge ref_clk);
    end

    send(8'hA5);
    wait_start();
    check_frame();

    repeat (4) begin
      b = 8'($urandom);
      send(b);
      wait_start();
      check_frame();
    end

    // back-to-back: second byte during START, third offered while full
    send(8'h93);
    wait_start();
    fork
      check_frame();
      begin
        repeat (10) @(negedge ref_clk);
        send(8'h4D);
        repeat (10) @(negedge ref_clk);
        chk("hold_full_ready", rdy, 0);
        valid = 1'b1;
        din = 8'hFF;
        repeat (100) @(negedge ref_clk);
        chk("hold_full_ready2", rdy, 0);
        valid = 1'b0;
      end
    join
    check_frame();

    // reset mid-frame with a pending byte
    send(8'h4D);
    wait_start();
    fork
      repeat (5 * 64 + 10) @(negedge ref_clk);
      begin
        repeat (10) @(negedge ref_clk);
        send(8'h12);
      end
    join
    reset = 1'b1;
    @(negedge ref_clk);
    reset = 1'b0;
    chk("rst_out", o, 0);
    chk("rst_ready", rdy, 1);
    chk("rst_busy", bsy, 0);
    q.delete();
    for (int i = 0; i < 300; i++) begin
      @(negedge ref_clk);
      chk("post_rst_out", o, 0);
      chk("post_rst_busy", bsy, 0);
    end
    send(8'h12);
    wait_start();
    check_frame();

    // two stop bits
    sel = 1'b1;
    @(negedge ref_clk);
    send(8'h00);
    wait_start();
    check_frame();
    repeat (2) begin
      b = 8'($urandom);
      send(b);
      wait_start();
      check_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
